// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// Module      : uart_arb_pkg
// Description : Shared constants and state encoding for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package uart_arb_pkg;

  localparam int UART_DATA_W = 8;

  // State encoding for the arbiter FSM
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_GAP   = ST_GAP
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// Module      : uart_tx_arbiter_rr_pick
// Description : Round-robin picker (rr_pick). Purely combinational: returns the
//               first asserted request at or after ptr, wrapping N_REQ-1 -> 0.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] grant
);

  localparam logic [PTR_W:0] N_WIDE = (PTR_W+1)'(N_REQ);

  logic [PTR_W:0] sum;

  // Walk offsets from farthest to nearest so the nearest requester wins last
  always_comb begin
    valid = |req;
    grant = '0;
    sum   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= N_WIDE) begin
        sum = sum - N_WIDE;
      end
      if (req[sum[PTR_W-1:0]]) begin
        grant = sum[PTR_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// Module      : uart_tx_arbiter
// Description : Shares one uart_txB transmitter between N_REQ byte requesters.
//               Round-robin grant, start pulse, wait for tx_done with timeout,
//               then a programmable inter-byte gap.
//               Optional macro UART_ARB_STATS_EN adds per-requester ack counts
//               on stat_cnt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int GAP_CYC  = 16,
  parameter int TOUT_CYC = 20000
) (
  input  logic                         clk,
  input  logic                         rst,        // asynchronous, active-low
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             ack,
  input  logic                         tx_en,
  input  logic                         tx_done,
  output logic                         tx_start,
  output logic [UART_DATA_W-1:0]       tx_data,
  output logic                         busy,
  output logic                         tout_err
`ifdef UART_ARB_STATS_EN
  ,
  output logic [16*N_REQ-1:0]          stat_cnt
`endif
);

  localparam int PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TOUT_W   = $clog2(TOUT_CYC) + 1;
  localparam int GAP_W    = $clog2(GAP_CYC + 1) + 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  localparam logic [TOUT_W-1:0] TOUT_END = TOUT_W'(TOUT_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_LAST);
  localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(N_REQ - 1);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              pick_valid;
  logic [PTR_W-1:0]  pick_idx;
  logic [TOUT_W-1:0] tout_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              grant_fire;
  logic              tout_hit;

  uart_tx_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .grant (pick_idx)
  );

  assign busy = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; tx_done beats a simultaneous timeout
  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    tout_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_valid && tx_en) begin
          grant_fire = 1'b1;
          state_nxt  = S_START;
        end
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          state_nxt = S_GAP;
        end else if (tout_cnt == TOUT_END) begin
          tout_hit  = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_END) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant capture: one-cycle ack, latched byte, then start pulse from START
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack      <= '0;
      tx_data  <= '0;
      gnt_idx  <= '0;
      tx_start <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= (state == S_START);
      if (grant_fire) begin
        ack[pick_idx] <= 1'b1;
        tx_data       <= req_data[pick_idx*UART_DATA_W +: UART_DATA_W];
        gnt_idx       <= pick_idx;
      end
    end
  end

  // Round-robin pointer advances past the requester just served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (state == S_START) begin
      rr_ptr <= (gnt_idx == PTR_MAX) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Timeout and gap counters; each is cleared in the state before its use
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tout_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_START: tout_cnt <= '0;
        S_WAIT: begin
          gap_cnt <= '0;
          if (tout_cnt != TOUT_END) begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt != GAP_END) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tout_err <= 1'b0;
    end else if (tout_hit) begin
      tout_err <= 1'b1;
    end
  end

`ifdef UART_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
      // Per-requester ack count, saturating at all-ones
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stat_cnt[gi*16 +: 16] <= '0;
        end else if (ack[gi] && (stat_cnt[gi*16 +: 16] != 16'hFFFF)) begin
          stat_cnt[gi*16 +: 16] <= stat_cnt[gi*16 +: 16] + 16'd1;
        end
      end
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (N_REQ=4, GAP_CYC=4,
//               TOUT_CYC=100). Stat counts are checked when UART_ARB_STATS_EN
//               is defined.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N_REQ    = 4;
  localparam int GAP_CYC  = 4;
  localparam int TOUT_CYC = 100;

  logic                 clk      = 1'b0;
  logic                 rst      = 1'b0;
  logic [N_REQ-1:0]     req      = '0;
  logic [8*N_REQ-1:0]   req_data = '0;
  logic [N_REQ-1:0]     ack;
  logic                 tx_en    = 1'b1;
  logic                 tx_done  = 1'b0;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 busy;
  logic                 tout_err;
`ifdef UART_ARB_STATS_EN
  logic [16*N_REQ-1:0]  stat_cnt;
`endif

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(
    .N_REQ    (N_REQ),
    .GAP_CYC  (GAP_CYC),
    .TOUT_CYC (TOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_en    (tx_en),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .tout_err (tout_err)
`ifdef UART_ARB_STATS_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic wait_ack(output logic [3:0] got, output int n);
    got = '0;
    n   = 0;
    while (got == 4'b0 && n < 300) begin
      tick();
      n++;
      got = ack;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
  endtask

  // One complete frame from IDLE: ack latency, start pulse, data, gap length
  task automatic do_frame(input string tag, input logic [3:0] r, input logic [31:0] d,
                          input logic [3:0] exp_ack, input logic [7:0] exp_data);
    int n;
    req      = r;
    req_data = d;
    tick();
    check({tag, " ack"}, ack, exp_ack);
    req = '0;
    tick();
    check({tag, " tx_start"}, tx_start, 1'b1);
    check({tag, " tx_data"}, tx_data, exp_data);
    check({tag, " ack pulse"}, ack, 4'b0);
    pulse_done(3);
    check({tag, " tx_data hold"}, tx_data, exp_data);
    wait_idle(n);
    check({tag, " gap cycles"}, n, GAP_CYC);
  endtask

  initial begin
    logic [3:0] got;
    int         n;
    int         bad;

    vecs[0] = '{4'b0001, 32'h000000B1, 4'b0001, 8'hB1};
    vecs[1] = '{4'b1111, 32'hD3D2D1D0, 4'b0010, 8'hD1};
    vecs[2] = '{4'b0001, 32'h44332211, 4'b0001, 8'h11};
    vecs[3] = '{4'b1001, 32'h88776655, 4'b1000, 8'h88};
    vecs[4] = '{4'b1100, 32'hCAFEBEEF, 4'b0100, 8'hFE};
    vecs[5] = '{4'b0110, 32'h0F1E2D3C, 4'b0010, 8'h2D};
    vecs[6] = '{4'b1000, 32'h5A000000, 4'b1000, 8'h5A};

    // Reset state
    tick();
    tick();
    rst = 1'b1;
    check("reset ack", ack, 4'b0);
    check("reset tx_start", tx_start, 1'b0);
    check("reset tx_data", tx_data, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset tout_err", tout_err, 1'b0);

    // All four requesting from rr_ptr=0: order 0,1,2,3 with gap after tx_done
    req_data = 32'h44332211;
    req      = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_ack(got, n);
      check($sformatf("rr order %0d", k), got, 4'b0001 << k);
      if (k > 0) check($sformatf("rr gap %0d", k), (n >= GAP_CYC), 1'b1);
      req = req & ~got;
      tick();
      check($sformatf("rr tx_start %0d", k), tx_start, 1'b1);
      check($sformatf("rr tx_data %0d", k), tx_data, 8'h11 * (k + 1));
      pulse_done(9);
    end
    wait_idle(n);
    check("rr final idle", busy, 1'b0);

    // Table of single frames; rr_ptr carries from one record to the next
    for (int i = 0; i < 7; i++) begin
      do_frame($sformatf("vec%0d", i), vecs[i].req, vecs[i].data,
               vecs[i].exp_ack, vecs[i].exp_data);
    end

    // tx_en low holds off the grant; raising it grants on the next cycle
    tx_en    = 1'b0;
    req_data = 32'h33445566;
    req      = 4'b0100;
    bad      = 0;
    repeat (50) begin
      tick();
      if (ack != 4'b0 || tx_start || busy) bad++;
    end
    check("tx_en low no grant", bad, 0);
    tx_en = 1'b1;
    tick();
    check("tx_en high ack", ack, 4'b0100);
    req = '0;
    tick();
    check("tx_en high tx_data", tx_data, 8'h44);
    pulse_done(3);
    wait_idle(n);

    // tx_done on the very cycle the timeout would fire: no error
    req      = 4'b1000;
    req_data = 32'hE7000000;
    tick();
    check("tie ack", ack, 4'b1000);
    req = '0;
    tick();
    check("tie tx_start", tx_start, 1'b1);
    repeat (99) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("tie tout_err", tout_err, 1'b0);
    check("tie busy in gap", busy, 1'b1);
    wait_idle(n);
    check("tie gap cycles", n, GAP_CYC);

    // tx_done never comes: tout_err exactly TOUT_CYC cycles after tx_start
    req      = 4'b0001;
    req_data = 32'h000000C3;
    tick();
    check("tout ack", ack, 4'b0001);
    req = '0;
    tick();
    check("tout tx_start", tx_start, 1'b1);
    repeat (TOUT_CYC - 1) tick();
    check("tout early", tout_err, 1'b0);
    tick();
    check("tout set", tout_err, 1'b1);
    wait_idle(n);
    check("tout gap cycles", n, GAP_CYC);
    check("tout sticky", tout_err, 1'b1);

    // Reset in WAIT: outputs clear asynchronously, pointer restarts at 0
    req      = 4'b0010;
    req_data = 32'h00007700;
    tick();
    check("rst ack", ack, 4'b0010);
    req = 4'b1001;
    tick();
    check("rst tx_start pre", tx_start, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("rst async tx_start", tx_start, 1'b0);
    check("rst async busy", busy, 1'b0);
    check("rst async tx_data", tx_data, 8'h00);
    check("rst async ack", ack, 4'b0);
    check("rst async tout_err", tout_err, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("rst regrant ptr0", ack, 4'b0001);
    req = '0;
    tick();
    check("rst regrant tx_start", tx_start, 1'b1);
    pulse_done(2);
    wait_idle(n);

`ifdef UART_ARB_STATS_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      do_frame($sformatf("stat%0d", j), 4'b0010, 32'h0000A500, 4'b0010, 8'hA5);
    end
    check("stat_cnt", stat_cnt, 64'h0000_0000_0003_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
